fm_wb_scheduler: RTL and testbench
==================================

Name: fm_wb_scheduler

Overview:
- Sequences feature-map write-back from the PE rows into the fm buffer write port.
- Arbitrates round-robin among N_REQ row requesters (valid/ready streams), one word per cycle.
- Generates per-row region addresses and signals layer completion.
- Owns the fm ping-pong bank select: toggles it once all rows have delivered their regions, so the next layer reads the freshly written bank.

Parameters:
- N_REQ, 4, number of write-back requesters (PE rows).
- DATA_W, 8, write-back word width.
- DEPTH, 1024, fm buffer bank depth in words.
- ADDR_W, $clog2(DEPTH), address width (derived; not overridden).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  one-cycle pulse; latches region_len and begins a layer. Honoured only in IDLE.
- region_len  input  ADDR_W+1  words each requester must deliver this layer.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle completion pulse.
- cfg_err  output  1  sticky; set when a start is rejected for overflow; cleared by the next accepted start.
- req_valid  input  N_REQ  per-row data valid.
- req_data  input  N_REQ x DATA_W  per-row data (packed [N_REQ-1:0][DATA_W-1:0]).
- req_ready  output  N_REQ  one-hot grant; combinational from req_valid and state.
- wr_en  output  1  fm buffer write enable, registered.
- wr_addr  output  ADDR_W  fm buffer write address, registered.
- wr_data  output  DATA_W  fm buffer write data, registered.
- ping_pong  output  1  bank currently being written; readers use the opposite bank.

Behaviour:
- Reset values: busy=0, done=0, cfg_err=0, wr_en=0, wr_addr=0, wr_data=0, ping_pong=0, all counters=0, round-robin pointer=0, state=IDLE.
- States:
  - IDLE: start with N_REQ*region_len > DEPTH (width ADDR_W+clog2(N_REQ)+2 compare) -> cfg_err=1, stay IDLE, no busy, no toggle.
  - IDLE: start with region_len==0 -> FIN.
  - IDLE: other starts -> latch len, compute base[i]=i*len (adder chain, registered), clear cnt[i], RUN.
  - RUN: per cycle, eligible[i] = req_valid[i] && cnt[i] < len. Grant = first eligible index at or after (last_grant+1) mod N_REQ. req_ready = grant one-hot; all-zero if none eligible.
  - RUN: on grant i, next edge: wr_en=1, wr_addr=base[i]+cnt[i], wr_data=req_data[i], cnt[i]++, last_grant=i. No grant -> wr_en=0, pointer unchanged.
  - RUN -> FIN in the cycle the final word is granted, i.e. all cnt==len after the increment.
  - FIN (one cycle): done=1, busy=0, ping_pong toggles on the same edge done rises; -> IDLE.
- Latency: accept at edge t -> write visible at t+1. Last accept at t -> done and the new ping_pong at t+2.
- Requesters with cnt==len are never granted, even if valid.
- start outside IDLE is ignored: no latch, no effect on cfg_err.
- req_valid may drop without a grant; no state change results.
- Reset mid-layer: returns to the reset state immediately. Partial region contents are undefined. ping_pong returns to 0.

Decomposition:
- diff_core_pkg holds: wb_state_e enum (IDLE, RUN, FIN); CONF_FM_BUF_DEPTH as the DEPTH default; CONF_PE_ROW as the N_REQ default.
- Sub-module rr_arbiter (N parameter): inputs eligible and pointer; outputs grant one-hot and grant index. Purely combinational, reusable for the weight and guard write-back paths.

Test Plan:
- N_REQ=4, len=3, all valid continuously -> 12 writes on consecutive cycles.
  - Rows 0,1,2,3,0,...
  - wr_addr 0,3,6,9,1,4,7,10,2,5,8,11.
  - done 2 cycles after the 12th accept; ping_pong 0->1.
- len=2, only row 2 valid for 4 cycles, then all valid:
  - Row 2 writes addr 4,5 back-to-back, then is never granted again.
  - Rows 3,0,1 complete in round-robin order.
  - done pulses once.
- DEPTH=1024, N_REQ=4, start with len=300 -> cfg_err=1, busy stays 0, no wr_en. Next start with len=256 clears cfg_err and runs 1024 writes.
- start with len=0 -> no wr_en, done pulses 2 cycles after start, ping_pong toggles.
- start pulsed again mid-layer with a different len -> ignored; addresses still follow the original len.
- rst_n asserted during RUN after 5 writes -> all outputs at reset values immediately. A fresh start runs a full layer from addr 0 with ping_pong=0.

Source files
------------

// File: rtl/diff_core_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | diff_core_pkg : shared types and configuration defaults            |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
package diff_core_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } wb_state_e;

  localparam int CONF_FM_BUF_DEPTH = 1024;
  localparam int CONF_PE_ROW       = 4;

endpackage
`default_nettype wire

// File: rtl/fm_wb_scheduler_if.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | fm_wb_scheduler_if : control, row request and fm write-port bundle |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
interface fm_wb_scheduler_if
  import diff_core_pkg::*;
#(
  parameter int N_REQ  = CONF_PE_ROW,
  parameter int DATA_W = 8,
  parameter int DEPTH  = CONF_FM_BUF_DEPTH
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic                           start;
  logic [ADDR_W:0]                region_len;
  logic                           busy;
  logic                           done;
  logic                           cfg_err;
  logic [N_REQ-1:0]               req_valid;
  logic [N_REQ-1:0][DATA_W-1:0]   req_data;
  logic [N_REQ-1:0]               req_ready;
  logic                           wr_en;
  logic [ADDR_W-1:0]              wr_addr;
  logic [DATA_W-1:0]              wr_data;
  logic                           ping_pong;

  modport master (
    output start, region_len, req_valid, req_data,
    input  busy, done, cfg_err, req_ready, wr_en, wr_addr, wr_data, ping_pong
  );

  modport slave (
    input  start, region_len, req_valid, req_data,
    output busy, done, cfg_err, req_ready, wr_en, wr_addr, wr_data, ping_pong
  );

endinterface
`default_nettype wire

// File: rtl/fm_wb_scheduler_rr_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin pick starting at i_pointer  |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_eligible,
  input  logic [IDX_W-1:0] i_pointer,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_grant_idx,
  output logic             o_valid
);

  logic [IDX_W-1:0] w_idx;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_valid     = 1'b0;
    w_idx       = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = IDX_W'((int'(i_pointer) + k) % N);
      if (!o_valid && i_eligible[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = w_idx;
        o_valid        = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fm_wb_scheduler.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | fm_wb_scheduler : round-robin PE-row write-back into the fm buffer |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
module fm_wb_scheduler
  import diff_core_pkg::*;
#(
  parameter int N_REQ  = CONF_PE_ROW,
  parameter int DATA_W = 8,
  parameter int DEPTH  = CONF_FM_BUF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  fm_wb_scheduler_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LEN_W  = ADDR_W + 1;
  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CMP_W  = ADDR_W + $clog2(N_REQ) + 2;

  wb_state_e         r_state;
  wb_state_e         w_state_nxt;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_cnt  [N_REQ];
  logic [ADDR_W-1:0] r_base [N_REQ];
  logic [ADDR_W-1:0] w_base [N_REQ];
  logic [IDX_W-1:0]  r_ptr;
  logic [IDX_W-1:0]  w_gidx;
  logic [N_REQ-1:0]  w_elig;
  logic [N_REQ-1:0]  w_grant;
  logic              w_gvalid;
  logic              w_overflow;
  logic              w_accept;
  logic              w_reject;
  logic              w_last_word;
  logic              r_busy;
  logic              r_done;
  logic              r_cfg_err;
  logic              r_wr_en;
  logic              r_ping_pong;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;

  assign w_overflow = (CMP_W'(N_REQ) * CMP_W'(bus.region_len)) > CMP_W'(DEPTH);

  // Row bases are only captured for non-overflowing lengths, so ADDR_W bits suffice.
  always_comb begin
    w_base[0] = '0;
    for (int i = 1; i < N_REQ; i++) begin
      w_base[i] = w_base[i-1] + bus.region_len[ADDR_W-1:0];
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_elig
    assign w_elig[gi] = (r_state == RUN) && bus.req_valid[gi] && (r_cnt[gi] < r_len);
  end

  rr_arbiter #(.N(N_REQ), .IDX_W(IDX_W)) u_arb (
    .i_eligible  (w_elig),
    .i_pointer   (r_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_gidx),
    .o_valid     (w_gvalid)
  );

  always_comb begin
    w_last_word = w_gvalid;
    for (int i = 0; i < N_REQ; i++) begin
      if ((w_grant[i] ? r_cnt[i] + 1'b1 : r_cnt[i]) != r_len) begin
        w_last_word = 1'b0;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          if (w_overflow) begin
            w_reject = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = (bus.region_len == '0) ? FIN : RUN;
          end
        end
      end
      RUN:     if (w_last_word) w_state_nxt = FIN;
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len       <= '0;
      r_ptr       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_ping_pong <= 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
        r_cnt[i]  <= '0;
        r_base[i] <= '0;
      end
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      if (w_accept) begin
        r_len     <= bus.region_len;
        r_busy    <= 1'b1;
        r_cfg_err <= 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
          r_cnt[i]  <= '0;
          r_base[i] <= w_base[i];
        end
      end else if (w_reject) begin
        r_cfg_err <= 1'b1;
      end
      if (w_gvalid) begin
        r_wr_en       <= 1'b1;
        r_wr_addr     <= r_base[w_gidx] + r_cnt[w_gidx][ADDR_W-1:0];
        r_wr_data     <= bus.req_data[w_gidx];
        r_cnt[w_gidx] <= r_cnt[w_gidx] + 1'b1;
        r_ptr         <= (w_gidx == IDX_W'(N_REQ - 1)) ? '0 : w_gidx + 1'b1;
      end
      // Bank flips with done so readers see the freshly written bank immediately.
      if (r_state == FIN) begin
        r_done      <= 1'b1;
        r_busy      <= 1'b0;
        r_ping_pong <= ~r_ping_pong;
      end
    end
  end

  assign bus.req_ready = w_grant;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.cfg_err   = r_cfg_err;
  assign bus.wr_en     = r_wr_en;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;
  assign bus.ping_pong = r_ping_pong;

endmodule
`default_nettype wire

// File: tb/tb_fm_wb_scheduler.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_fm_wb_scheduler : directed scoreboard bench for fm_wb_scheduler |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
module tb_fm_wb_scheduler;

  logic clk;
  logic rst_n;

  fm_wb_scheduler_if #(.N_REQ(4), .DATA_W(8), .DEPTH(1024)) bus ();

  fm_wb_scheduler #(.N_REQ(4), .DATA_W(8), .DEPTH(1024)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp;
  int          n_err;
  int          m_state;
  int          m_ptr;
  int          m_writes;
  int          m_cnt [4];
  logic [10:0] m_len;
  logic        m_busy;
  logic        m_done;
  logic        m_cfg;
  logic        m_wr_en;
  logic        m_ping;
  logic [17:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state  = 0;
    m_ptr    = 0;
    m_len    = '0;
    m_busy   = 1'b0;
    m_done   = 1'b0;
    m_cfg    = 1'b0;
    m_wr_en  = 1'b0;
    m_ping   = 1'b0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    sb.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".busy"},    {31'd0, bus.busy},      32'd0);
    chk({tag, ".done"},    {31'd0, bus.done},      32'd0);
    chk({tag, ".cfg_err"}, {31'd0, bus.cfg_err},   32'd0);
    chk({tag, ".wr_en"},   {31'd0, bus.wr_en},     32'd0);
    chk({tag, ".wr_addr"}, {22'd0, bus.wr_addr},   32'd0);
    chk({tag, ".wr_data"}, {24'd0, bus.wr_data},   32'd0);
    chk({tag, ".ping"},    {31'd0, bus.ping_pong}, 32'd0);
  endtask

  // One clock: check registered outputs, drive inputs, predict grant and next state.
  task automatic tick(input logic st, input logic [10:0] len, input logic [3:0] v);
    logic [17:0] e;
    logic [3:0]  exp_rdy;
    int          g;
    int          idx;
    bit          all_done;
    @(negedge clk);
    chk("wr_en", {31'd0, bus.wr_en}, {31'd0, m_wr_en});
    if (m_wr_en && sb.size() > 0) begin
      e = sb.pop_front();
      chk("wr_addr", {22'd0, bus.wr_addr}, {22'd0, e[17:8]});
      chk("wr_data", {24'd0, bus.wr_data}, {24'd0, e[7:0]});
    end
    chk("busy",      {31'd0, bus.busy},      {31'd0, m_busy});
    chk("done",      {31'd0, bus.done},      {31'd0, m_done});
    chk("ping_pong", {31'd0, bus.ping_pong}, {31'd0, m_ping});
    chk("cfg_err",   {31'd0, bus.cfg_err},   {31'd0, m_cfg});
    bus.start      = st;
    bus.region_len = len;
    bus.req_valid  = v;
    for (int i = 0; i < 4; i++) bus.req_data[i] = {i[1:0], m_cnt[i][5:0]};
    #1;
    g = -1;
    if (m_state == 1) begin
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr + k) % 4;
        if (g < 0 && v[idx] && m_cnt[idx] < int'(m_len)) g = idx;
      end
    end
    exp_rdy = (g >= 0) ? 4'(1 << g) : 4'h0;
    chk("req_ready", {28'd0, bus.req_ready}, {28'd0, exp_rdy});
    m_wr_en = 1'b0;
    m_done  = 1'b0;
    case (m_state)
      0: if (st) begin
        if (4 * int'(len) > 1024) begin
          m_cfg = 1'b1;
        end else begin
          m_cfg   = 1'b0;
          m_busy  = 1'b1;
          m_len   = len;
          for (int i = 0; i < 4; i++) m_cnt[i] = 0;
          m_state = (len == 11'd0) ? 2 : 1;
        end
      end
      1: if (g >= 0) begin
        sb.push_back({10'(g * int'(m_len) + m_cnt[g]), g[1:0], m_cnt[g][5:0]});
        m_wr_en = 1'b1;
        m_cnt[g]++;
        m_writes++;
        m_ptr = (g + 1) % 4;
        all_done = 1'b1;
        for (int i = 0; i < 4; i++) if (m_cnt[i] != int'(m_len)) all_done = 1'b0;
        if (all_done) m_state = 2;
      end
      default: begin
        m_done  = 1'b1;
        m_busy  = 1'b0;
        m_ping  = ~m_ping;
        m_state = 0;
      end
    endcase
  endtask

  task automatic run_to_idle(input logic [3:0] v);
    int n;
    n = 0;
    while (m_state != 0 && n < 3000) begin
      tick(1'b0, 11'd0, v);
      n++;
    end
    chk("layer_timeout", n, (n < 3000) ? n : 0);
    repeat (2) tick(1'b0, 11'd0, 4'h0);
  endtask

  initial begin
    int w0;
    int n;
    n_cmp          = 0;
    n_err          = 0;
    m_writes       = 0;
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.region_len = '0;
    bus.req_valid  = '0;
    bus.req_data   = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    chk("reset.req_ready", {28'd0, bus.req_ready}, 32'd0);
    rst_n = 1'b1;

    // len=3, all rows valid
    tick(1'b1, 11'd3, 4'hF);
    run_to_idle(4'hF);

    // len=2, only row 2 valid at first
    tick(1'b1, 11'd2, 4'h4);
    repeat (4) tick(1'b0, 11'd0, 4'h4);
    run_to_idle(4'hF);

    // overflow rejected, then max legal length with a stray mid-layer start
    tick(1'b1, 11'd300, 4'hF);
    repeat (3) tick(1'b0, 11'd0, 4'hF);
    tick(1'b1, 11'd256, 4'hF);
    repeat (100) tick(1'b0, 11'd0, 4'hF);
    tick(1'b1, 11'd5, 4'hF);
    run_to_idle(4'hF);

    // zero-length layer
    tick(1'b1, 11'd0, 4'hF);
    repeat (3) tick(1'b0, 11'd0, 4'hF);

    // reset in the middle of a layer
    tick(1'b1, 11'd4, 4'hF);
    w0 = m_writes;
    n  = 0;
    while (m_writes < w0 + 5 && n < 50) begin
      tick(1'b0, 11'd0, 4'hF);
      n++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    chk("midreset.req_ready", {28'd0, bus.req_ready}, 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick(1'b1, 11'd3, 4'hF);
    run_to_idle(4'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
